// File: rtl/pbus_pkg.sv
// Shared definitions for the peripheral-bus arbiter: FSM states, slave map,
// GPIO register offsets and the unmapped-read marker word.
package pbus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } pbus_state_e;

   localparam logic [2:0] SLV_GPIO   = 3'd0;
   localparam logic [2:0] SLV_PERIPH1 = 3'd1;
   localparam logic [2:0] SLV_PERIPH2 = 3'd2;
   localparam logic [2:0] SLV_PERIPH3 = 3'd3;

   localparam logic [16:0] GPIO_IN_OFS  = 17'h00000;
   localparam logic [16:0] GPIO_OUT_OFS = 17'h00008;
   localparam logic [16:0] GPIO_DIR_OFS = 17'h00010;

   localparam logic [31:0] PBUS_DEADBEEF = 32'hDEAD_BEEF;

   function automatic logic slv_mapped(input logic [2:0] idx, input int unsigned nslv);
      return 32'(idx) < nslv;
   endfunction

endpackage

// File: rtl/pbus_rr_arb.sv
// Two-requester round-robin grant; the last-winner pointer only advances
// when the caller accepts the grant (take_i).
module pbus_rr_arb (
   input  logic clk,
   input  logic rst,
   input  logic req0_i,
   input  logic req1_i,
   input  logic take_i,
   output logic gnt_o,
   output logic any_o
);

   logic last_q, last_d;

   always_comb begin
      any_o  = req0_i | req1_i;
      // On a tie the requester that did not win last time is chosen.
      gnt_o  = (req0_i && req1_i) ? ~last_q : req1_i;
      last_d = last_q;
      if (take_i && any_o) last_d = gnt_o;
   end

   always_ff @(posedge clk) begin
      if (rst) last_q <= 1'b1;
      else     last_q <= last_d;
   end

endmodule

// File: rtl/pbus_arbiter.sv
// Two-master peripheral bus arbiter/sequencer (IDLE->ADDR->[DATA]->RESP).
// Optional feature macro: PBUS_ARB_ERR_EN adds bus_err for unmapped slaves.
module pbus_arbiter
   import pbus_pkg::*;
#(
   parameter int unsigned NSLV   = 4,
   parameter int unsigned RD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_req,
   input  logic [19:0]     m0_addr,
   input  logic [3:0]      m0_we,
   input  logic            m0_re,
   input  logic [31:0]     m0_wdata,
   output logic            m0_gnt,
   output logic            m0_done,
   output logic [31:0]     m0_rdata,
   input  logic            m1_req,
   input  logic [19:0]     m1_addr,
   input  logic [3:0]      m1_we,
   input  logic            m1_re,
   input  logic [31:0]     m1_wdata,
   output logic            m1_gnt,
   output logic            m1_done,
   output logic [31:0]     m1_rdata,
   output logic [NSLV-1:0] slv_ce,
   output logic [3:0]      bus_we,
   output logic            bus_re,
   output logic [16:0]     bus_addr,
   output logic [31:0]     bus_wdata,
   input  logic [31:0]     bus_rdata
`ifdef PBUS_ARB_ERR_EN
   ,
   output logic            bus_err
`endif
);

   localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

   pbus_state_e state_q, state_d;
   logic        own_q, own_d;
   logic [3:0]  we_q, we_d;
   logic        re_q, re_d;
   logic [16:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  idx_q, idx_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] m0_rdata_q, m0_rdata_d;
   logic [31:0] m1_rdata_q, m1_rdata_d;

   logic        arb_sel, arb_any;
   logic        mapped, is_read, addr_phase;
   logic [31:0] rd_val;

   pbus_rr_arb u_rr (
      .clk    (clk),
      .rst    (rst),
      .req0_i (m0_req),
      .req1_i (m1_req),
      .take_i (state_q == ST_IDLE),
      .gnt_o  (arb_sel),
      .any_o  (arb_any)
   );

   assign mapped     = slv_mapped(idx_q, NSLV);
   // A nonzero byte-enable wins over re; we=0/re=0 is a null write-path cycle.
   assign is_read    = (we_q == 4'b0000) && re_q;
   assign addr_phase = (state_q == ST_ADDR);

`ifdef PBUS_ARB_ERR_EN
   assign rd_val  = mapped ? bus_rdata : PBUS_DEADBEEF;
   assign bus_err = (state_q == ST_RESP) && !mapped;
`else
   assign rd_val  = mapped ? bus_rdata : '0;
`endif

   always_comb begin
      state_d    = state_q;
      own_d      = own_q;
      we_d       = we_q;
      re_d       = re_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               own_d   = arb_sel;
               we_d    = arb_sel ? m1_we         : m0_we;
               re_d    = arb_sel ? m1_re         : m0_re;
               addr_d  = arb_sel ? m1_addr[16:0] : m0_addr[16:0];
               idx_d   = arb_sel ? m1_addr[19:17] : m0_addr[19:17];
               wdata_d = arb_sel ? m1_wdata      : m0_wdata;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            cnt_d   = '0;
            state_d = is_read ? ST_DATA : ST_RESP;
         end
         ST_DATA: begin
            if (cnt_q == LAST_CNT) begin
               if (own_q) m1_rdata_d = rd_val;
               else       m0_rdata_d = rd_val;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      slv_ce = '0;
      if (addr_phase && mapped) begin
         for (int unsigned i = 0; i < NSLV; i++) begin
            if (32'(idx_q) == i) slv_ce[i] = 1'b1;
         end
      end
      bus_we    = addr_phase ? we_q    : '0;
      bus_re    = addr_phase && is_read;
      bus_addr  = addr_phase ? addr_q  : '0;
      bus_wdata = addr_phase ? wdata_q : '0;
      m0_gnt    = addr_phase && !own_q;
      m1_gnt    = addr_phase &&  own_q;
      m0_done   = (state_q == ST_RESP) && !own_q;
      m1_done   = (state_q == ST_RESP) &&  own_q;
   end

   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         own_q      <= 1'b0;
         we_q       <= '0;
         re_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         own_q      <= own_d;
         we_q       <= we_d;
         re_q       <= re_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

endmodule

// File: tb/tb_pbus_arbiter.sv
// Bench for pbus_arbiter: directed scenarios plus random traffic against a
// byte-addressed reference memory and a round-robin ownership model.
module tb_pbus_arbiter;
   import pbus_pkg::*;

   localparam int NSLV   = 3;
   localparam int RD_LAT = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            m0_req, m0_re, m0_gnt, m0_done;
   logic [19:0]     m0_addr;
   logic [3:0]      m0_we;
   logic [31:0]     m0_wdata, m0_rdata;
   logic            m1_req, m1_re, m1_gnt, m1_done;
   logic [19:0]     m1_addr;
   logic [3:0]      m1_we;
   logic [31:0]     m1_wdata, m1_rdata;
   logic [NSLV-1:0] slv_ce;
   logic [3:0]      bus_we;
   logic            bus_re;
   logic [16:0]     bus_addr;
   logic [31:0]     bus_wdata, bus_rdata;
`ifdef PBUS_ARB_ERR_EN
   logic            bus_err;
`endif

   int vectors = 0;
   int miscompares = 0;

   pbus_arbiter #(.NSLV(NSLV), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_re(m0_re),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_re(m1_re),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
      .slv_ce(slv_ce), .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
`ifdef PBUS_ARB_ERR_EN
      , .bus_err(bus_err)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- slave side: memories behind chip selects ----------------
   logic [31:0] slv_mem [int];
   logic [31:0] pipe_d [RD_LAT];
   bit          pipe_v [RD_LAT];
   logic [31:0] garbage = 32'hBAD0_0001;

   // Undriven bus floats: represented by nonzero junk the arbiter must ignore.
   assign bus_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : garbage;

   always @(posedge clk) begin
      int          key;
      logic [31:0] v;
      for (int i = RD_LAT - 1; i > 0; i--) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_d[i] <= pipe_d[i-1];
      end
      pipe_v[0] <= 1'b0;
      garbage   <= $urandom | 32'h1;
      if (slv_ce != '0) begin
         key = 0;
         for (int s = 0; s < NSLV; s++) if (slv_ce[s]) key = s * 131072 + int'(bus_addr);
         v = slv_mem.exists(key) ? slv_mem[key] : 32'h0;
         if (bus_we != 4'b0000) begin
            for (int b = 0; b < 4; b++) if (bus_we[b]) v[8*b +: 8] = bus_wdata[8*b +: 8];
            slv_mem[key] = v;
         end
         if (bus_re) begin
            pipe_v[0] <= 1'b1;
            pipe_d[0] <= v;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [int];
   bit          ref_last = 1'b1;

   function automatic bit ref_mapped(input logic [19:0] a);
      return int'(a[19:17]) < NSLV;
   endfunction

   function automatic int ref_key(input logic [19:0] a);
      return int'(a[19:17]) * 131072 + int'(a[16:0]);
   endfunction

   function automatic logic [31:0] ref_read(input logic [19:0] a);
      if (!ref_mapped(a)) begin
`ifdef PBUS_ARB_ERR_EN
         return 32'hDEADBEEF;
`else
         return 32'h0;
`endif
      end
      return ref_mem.exists(ref_key(a)) ? ref_mem[ref_key(a)] : 32'h0;
   endfunction

   function automatic void ref_write(input logic [19:0] a, input logic [3:0] w, input logic [31:0] d);
      logic [31:0] v;
      if (!ref_mapped(a) || w == 4'b0000) return;
      v = ref_mem.exists(ref_key(a)) ? ref_mem[ref_key(a)] : 32'h0;
      for (int b = 0; b < 4; b++) if (w[b]) v[8*b +: 8] = d[8*b +: 8];
      ref_mem[ref_key(a)] = v;
   endfunction

   function automatic logic [NSLV-1:0] ref_ce(input logic [19:0] a);
      logic [NSLV-1:0] one = 1;
      return ref_mapped(a) ? (one << a[19:17]) : '0;
   endfunction

   // ---------------- transaction driver (observes, does not judge) ----------------
   task automatic run_txn(input bit m, input logic [19:0] a, input logic [3:0] w, input logic r,
                          input logic [31:0] d, output logic [31:0] rd, output int cyc,
                          output int gnts, output logic [NSLV-1:0] ce_s, output logic [3:0] we_s,
                          output logic re_s, output logic [16:0] addr_s, output logic [31:0] wd_s,
                          output logic err_s, output bit stray);
      rd = '0; cyc = -1; gnts = 0; ce_s = '0; we_s = '0; re_s = 1'b0;
      addr_s = '0; wd_s = '0; err_s = 1'b0; stray = 1'b0;
      if (!m) begin
         m0_addr = a; m0_we = w; m0_re = r; m0_wdata = d; m0_req = 1'b1;
      end else begin
         m1_addr = a; m1_we = w; m1_re = r; m1_wdata = d; m1_req = 1'b1;
      end
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (m ? m1_gnt : m0_gnt) begin
            gnts++;
            ce_s = slv_ce; we_s = bus_we; re_s = bus_re; addr_s = bus_addr; wd_s = bus_wdata;
         end else if (slv_ce != '0) begin
            stray = 1'b1;
         end
         if (m ? (m0_gnt | m0_done) : (m1_gnt | m1_done)) stray = 1'b1;
         if (m ? m1_done : m0_done) begin
            rd  = m ? m1_rdata : m0_rdata;
`ifdef PBUS_ARB_ERR_EN
            err_s = bus_err;
`endif
            cyc = c;
            break;
         end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      @(posedge clk); #1;
   endtask

   logic [31:0]     t_rd;
   int              t_cyc, t_gnts;
   logic [NSLV-1:0] t_ce;
   logic [3:0]      t_we;
   logic            t_re, t_err;
   logic [16:0]     t_addr;
   logic [31:0]     t_wd;
   bit              t_stray;

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({slv_ce, bus_we, bus_re, bus_addr, bus_wdata, m0_gnt, m1_gnt, m0_done, m1_done} !== '0) begin
         miscompares++;
         $display("FAIL reset_bus: ce=%b we=%b re=%b addr=%h wd=%h gnt=%b%b done=%b%b required all 0",
                  slv_ce, bus_we, bus_re, bus_addr, bus_wdata, m0_gnt, m1_gnt, m0_done, m1_done);
      end
      vectors++;
      if ({m0_rdata, m1_rdata} !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_rdata: m0=%h m1=%h required 0", m0_rdata, m1_rdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      ref_last = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_gpio_dir;
      logic [19:0] a = {SLV_GPIO, GPIO_DIR_OFS};
      run_txn(1'b0, a, 4'b0011, 1'b0, 32'h000000FF, t_rd, t_cyc, t_gnts, t_ce, t_we, t_re,
              t_addr, t_wd, t_err, t_stray);
      ref_write(a, 4'b0011, 32'h000000FF); ref_last = 1'b0;
      vectors++;
      if ({t_ce, t_we, t_re, t_addr, t_wd} !== {3'b001, 4'b0011, 1'b0, 17'h00010, 32'h000000FF}) begin
         miscompares++;
         $display("FAIL dir_write_bus: ce=%b we=%b re=%b addr=%h wd=%h required 001/0011/0/00010/000000ff",
                  t_ce, t_we, t_re, t_addr, t_wd);
      end
      vectors++;
      if (t_cyc !== 3 || t_gnts !== 1 || t_stray) begin
         miscompares++;
         $display("FAIL dir_write_timing: done_cycle=%0d gnts=%0d stray=%0d required 3/1/0", t_cyc, t_gnts, t_stray);
      end
      run_txn(1'b0, a, 4'b0000, 1'b1, 32'h0, t_rd, t_cyc, t_gnts, t_ce, t_we, t_re,
              t_addr, t_wd, t_err, t_stray);
      vectors++;
      if (t_rd !== 32'h000000FF || t_cyc !== 3 + RD_LAT || t_re !== 1'b1) begin
         miscompares++;
         $display("FAIL dir_readback: rdata=%h cycle=%0d re=%b required 000000ff/%0d/1", t_rd, t_cyc, t_re, 3 + RD_LAT);
      end
   endtask

   task automatic test_gpio_out;
      logic [19:0] a = {SLV_GPIO, GPIO_OUT_OFS};
      run_txn(1'b0, a, 4'b1100, 1'b0, 32'h5AA50000, t_rd, t_cyc, t_gnts, t_ce, t_we, t_re,
              t_addr, t_wd, t_err, t_stray);
      ref_write(a, 4'b1100, 32'h5AA50000);
      run_txn(1'b0, a, 4'b0000, 1'b1, 32'h0, t_rd, t_cyc, t_gnts, t_ce, t_we, t_re,
              t_addr, t_wd, t_err, t_stray);
      vectors++;
      if (t_rd[31:16] !== 16'h5AA5 || t_cyc !== 4) begin
         miscompares++;
         $display("FAIL out_readback: rdata_hi=%h cycle=%0d required 5aa5/4", t_rd[31:16], t_cyc);
      end
   endtask

   task automatic test_round_robin;
      int          order [4];
      logic [31:0] got [4];
      int          n = 0;
      bit          ovl = 1'b0, w;
      logic [19:0] a0 = {SLV_GPIO, GPIO_DIR_OFS};
      logic [19:0] a1 = {SLV_GPIO, GPIO_OUT_OFS};
      m0_addr = a0; m0_we = 4'b0000; m0_re = 1'b1;
      m1_addr = a1; m1_we = 4'b0000; m1_re = 1'b1;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int c = 0; c < 80 && n < 4; c++) begin
         @(negedge clk);
         if ((m0_gnt && m1_gnt) || $countones(slv_ce) > 1 || (m0_done && m1_done)) ovl = 1'b1;
         if (m0_done && n < 4) begin order[n] = 0; got[n] = m0_rdata; n++; end
         else if (m1_done && n < 4) begin order[n] = 1; got[n] = m1_rdata; n++; end
         if (n == 4) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (n !== 4 || ovl) begin
         miscompares++;
         $display("FAIL rr_progress: completions=%0d overlap=%0d required 4/0", n, ovl);
      end
      for (int k = 0; k < 4 && k < n; k++) begin
         w = ~ref_last;
         ref_last = w;
         vectors++;
         if (order[k] !== int'(w) || got[k] !== ref_read(w ? a1 : a0)) begin
            miscompares++;
            $display("FAIL rr_order[%0d]: master=%0d rdata=%h required %0d/%h",
                     k, order[k], got[k], w, ref_read(w ? a1 : a0));
         end
      end
   endtask

   task automatic test_unmapped;
      logic [19:0] a = 20'h60000;
      run_txn(1'b1, a, 4'b0000, 1'b1, 32'h0, t_rd, t_cyc, t_gnts, t_ce, t_we, t_re,
              t_addr, t_wd, t_err, t_stray);
      ref_last = 1'b1;
      vectors++;
      if (t_ce !== '0 || t_gnts !== 1 || t_stray || t_cyc !== 3 + RD_LAT) begin
         miscompares++;
         $display("FAIL unmapped_ce: ce=%b gnts=%0d stray=%0d cycle=%0d required 000/1/0/%0d",
                  t_ce, t_gnts, t_stray, t_cyc, 3 + RD_LAT);
      end
      vectors++;
      if (t_rd !== ref_read(a)) begin
         miscompares++;
         $display("FAIL unmapped_rdata: got %h required %h", t_rd, ref_read(a));
      end
`ifdef PBUS_ARB_ERR_EN
      vectors++;
      if (t_err !== 1'b1) begin
         miscompares++;
         $display("FAIL unmapped_err: got %b required 1", t_err);
      end
`endif
   endtask

   task automatic test_we_over_re;
      logic [19:0] a = {SLV_GPIO, GPIO_OUT_OFS};
      run_txn(1'b0, a, 4'b0001, 1'b1, 32'h123456C3, t_rd, t_cyc, t_gnts, t_ce, t_we, t_re,
              t_addr, t_wd, t_err, t_stray);
      ref_write(a, 4'b0001, 32'h123456C3); ref_last = 1'b0;
      vectors++;
      if (t_re !== 1'b0 || t_we !== 4'b0001 || t_ce !== 3'b001 || t_cyc !== 3) begin
         miscompares++;
         $display("FAIL we_over_re: re=%b we=%b ce=%b cycle=%0d required 0/0001/001/3", t_re, t_we, t_ce, t_cyc);
      end
      run_txn(1'b0, a, 4'b0000, 1'b1, 32'h0, t_rd, t_cyc, t_gnts, t_ce, t_we, t_re,
              t_addr, t_wd, t_err, t_stray);
      vectors++;
      if (t_rd !== 32'h5AA500C3) begin
         miscompares++;
         $display("FAIL out_low_byte: got %h required 5aa500c3", t_rd);
      end
   endtask

   task automatic test_reset_mid;
      bit saw_gnt = 1'b0, saw_done = 1'b0;
      logic [19:0] a = {SLV_GPIO, GPIO_IN_OFS};
      m0_addr = {SLV_GPIO, GPIO_DIR_OFS}; m0_we = 4'b0000; m0_re = 1'b1; m0_req = 1'b1;
      for (int c = 0; c < 10 && !saw_gnt; c++) begin
         @(negedge clk);
         saw_gnt = m0_gnt;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; m0_req = 1'b0;
      ref_last = 1'b1;
      vectors++;
      if (!saw_gnt || {slv_ce, bus_we, bus_re, bus_addr, bus_wdata, m0_gnt, m1_gnt, m0_done, m1_done,
                       m0_rdata, m1_rdata} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_state: gnt_seen=%0d ce=%b re=%b done=%b%b m0_rdata=%h required 1/all 0",
                  saw_gnt, slv_ce, bus_re, m0_done, m1_done, m0_rdata);
      end
      repeat (4) begin
         @(negedge clk);
         if (m0_done || m1_done) saw_done = 1'b1;
      end
      @(posedge clk); #1;
      vectors++;
      if (saw_done) begin
         miscompares++;
         $display("FAIL mid_reset_done: done pulse seen=1 required 0");
      end
      run_txn(1'b0, a, 4'b1111, 1'b0, 32'hCAFE1234, t_rd, t_cyc, t_gnts, t_ce, t_we, t_re,
              t_addr, t_wd, t_err, t_stray);
      ref_write(a, 4'b1111, 32'hCAFE1234);
      run_txn(1'b0, a, 4'b0000, 1'b1, 32'h0, t_rd, t_cyc, t_gnts, t_ce, t_we, t_re,
              t_addr, t_wd, t_err, t_stray);
      ref_last = 1'b0;
      vectors++;
      if (t_rd !== 32'hCAFE1234 || t_cyc !== 3 + RD_LAT) begin
         miscompares++;
         $display("FAIL post_reset_txn: rdata=%h cycle=%0d required cafe1234/%0d", t_rd, t_cyc, 3 + RD_LAT);
      end
   endtask

   task automatic test_random;
      logic [16:0] ofs [4] = '{17'h00000, 17'h00004, 17'h00008, 17'h00010};
      for (int n = 0; n < 40; n++) begin
         bit          m  = 1'($urandom_range(0, 1));
         logic [19:0] a  = {3'($urandom_range(0, 4)), ofs[$urandom_range(0, 3)]};
         logic [3:0]  w  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         logic        r  = 1'($urandom_range(0, 1));
         logic [31:0] d  = $urandom;
         bit          rd_txn = (w == 4'b0000) && r;
         logic [31:0] exp_rd = ref_read(a);
         run_txn(m, a, w, r, d, t_rd, t_cyc, t_gnts, t_ce, t_we, t_re, t_addr, t_wd, t_err, t_stray);
         ref_write(a, w, d);
         ref_last = m;
         vectors++;
         if ({t_ce, t_we, t_re, t_addr, t_wd} !== {ref_ce(a), w, rd_txn, a[16:0], d}) begin
            miscompares++;
            $display("FAIL rand_bus[%0d]: ce=%b we=%b re=%b addr=%h wd=%h required %b/%b/%b/%h/%h",
                     n, t_ce, t_we, t_re, t_addr, t_wd, ref_ce(a), w, rd_txn, a[16:0], d);
         end
         vectors++;
         if (t_cyc !== (rd_txn ? 3 + RD_LAT : 3) || t_gnts !== 1 || t_stray) begin
            miscompares++;
            $display("FAIL rand_timing[%0d]: cycle=%0d gnts=%0d stray=%0d required %0d/1/0",
                     n, t_cyc, t_gnts, t_stray, rd_txn ? 3 + RD_LAT : 3);
         end
         if (rd_txn) begin
            vectors++;
            if (t_rd !== exp_rd) begin
               miscompares++;
               $display("FAIL rand_rdata[%0d]: master=%0d addr=%h got %h required %h", n, m, a, t_rd, exp_rd);
            end
         end
`ifdef PBUS_ARB_ERR_EN
         vectors++;
         if (t_err !== !ref_mapped(a)) begin
            miscompares++;
            $display("FAIL rand_err[%0d]: got %b required %b", n, t_err, !ref_mapped(a));
         end
`endif
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      m0_req = 1'b0; m0_addr = '0; m0_we = '0; m0_re = 1'b0; m0_wdata = '0;
      m1_req = 1'b0; m1_addr = '0; m1_we = '0; m1_re = 1'b0; m1_wdata = '0;
      test_reset;
      test_gpio_dir;
      test_gpio_out;
      test_round_robin;
      test_unmapped;
      test_we_over_re;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
